// File: rtl/dm_csr_file.sv
// Debug-module CSR file: DMI address decode, data/control registers and a
// fixed-latency abstract-command engine with busy/cmderr tracking.
module dm_csr_file #(
  parameter int DataCount  = 2,
  parameter int BusyCycles = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [6:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic [31:0] cmd_o,
  output logic        cmd_start_o,
  output logic        cmd_done_o
);
  localparam int          CW         = $clog2(BusyCycles + 1);
  localparam logic [7:0]  DataBase   = 8'h04;
  localparam logic [7:0]  AddrDmCtrl = 8'h10;
  localparam logic [7:0]  AddrAbsCs  = 8'h16;
  localparam logic [7:0]  AddrCmd    = 8'h17;

  localparam logic [2:0]  ErrBusy    = 3'd1;
  localparam logic [2:0]  ErrNotSup  = 3'd2;

  logic [7:0] addr;
  assign addr = {1'b0, addr_i};

  logic [DataCount-1:0][31:0] data_q, data_d;
  logic                       dmactive_q, dmactive_d;
  logic                       haltreq_q, haltreq_d;
  logic [2:0]                 cmderr_q, cmderr_d;
  logic                       busy_q, busy_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [31:0]                cmd_q, cmd_d;
  logic                       start_q, start_d;
  logic                       done_q, done_d;
  logic                       rvalid_q;
  logic [31:0]                rdata_q, rdata_d;
  logic [31:0]                rd_val;
  logic                       complete;

  assign complete = busy_q && (cnt_q == CW'(1));

  // Read mux reflects current register state; completion effects land next cycle.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DataCount; i++) begin
      if (addr == DataBase + 8'(i)) rd_val = data_q[i];
    end
    case (addr)
      AddrDmCtrl: rd_val = {haltreq_q, 30'b0, dmactive_q};
      AddrAbsCs:  rd_val = {19'b0, busy_q, 1'b0, cmderr_q, 4'b0, 4'(DataCount)};
      default: ;
    endcase
    rdata_d = (req_i && !we_i) ? rd_val : '0;
  end

  always_comb begin
    data_d     = data_q;
    dmactive_d = dmactive_q;
    haltreq_d  = haltreq_q;
    cmderr_d   = cmderr_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    start_d    = 1'b0;
    done_d     = 1'b0;

    if (busy_q) begin
      if (complete) begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        cnt_d     = '0;
        data_d[0] = data_q[0] + 32'd1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    if (req_i && we_i) begin
      // Data writes during a command (including its final cycle) are dropped.
      for (int i = 0; i < DataCount; i++) begin
        if (addr == DataBase + 8'(i)) begin
          if (busy_q) begin
            if (cmderr_q == 3'd0) cmderr_d = ErrBusy;
          end else begin
            data_d[i] = wdata_i;
          end
        end
      end
      case (addr)
        AddrDmCtrl: begin
          dmactive_d = wdata_i[0];
          haltreq_d  = wdata_i[31];
          if (!wdata_i[0]) begin
            data_d   = '0;
            cmderr_d = '0;
            busy_d   = 1'b0;
            cnt_d    = '0;
            cmd_d    = '0;
            done_d   = 1'b0;
          end
        end
        AddrAbsCs: cmderr_d = cmderr_q & ~wdata_i[10:8];
        AddrCmd: begin
          if (cmderr_q != 3'd0) begin
            cmderr_d = cmderr_q;
          end else if (busy_q) begin
            cmderr_d = ErrBusy;
          end else if (wdata_i[31:24] != 8'd0) begin
            cmderr_d = ErrNotSup;
          end else begin
            cmd_d   = wdata_i;
            start_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = CW'(BusyCycles);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      dmactive_q <= 1'b0;
      haltreq_q  <= 1'b0;
      cmderr_q   <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      data_q     <= data_d;
      dmactive_q <= dmactive_d;
      haltreq_q  <= haltreq_d;
      cmderr_q   <= cmderr_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      start_q    <= start_d;
      done_q     <= done_d;
      rvalid_q   <= req_i;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign cmd_o       = cmd_q;
  assign cmd_start_o = start_q;
  assign cmd_done_o  = done_q;
endmodule

// File: tb/tb_dm_csr_file.sv
// Bench for dm_csr_file: directed scenarios plus random traffic against a
// cycle-indexed behavioural model (commands tracked by their end cycle).
module tb_dm_csr_file;
  localparam int DC = 2;
  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [6:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        rvalid, busy, cmd_start, cmd_done;
  logic [31:0] rdata, cmd;

  dm_csr_file #(.DataCount(DC), .BusyCycles(BC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
    .cmd_o(cmd), .cmd_start_o(cmd_start), .cmd_done_o(cmd_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // model state
  logic [31:0] m_data [DC];
  logic        m_dmact, m_halt;
  logic [2:0]  m_err;
  logic [31:0] m_cmd;
  bit          m_act;
  int          m_end;
  int          cyc = 0;
  bit          e_rvalid, e_start, e_done;
  logic [31:0] e_rdata;

  task automatic model_reset();
    for (int i = 0; i < DC; i++) m_data[i] = '0;
    m_dmact = 0; m_halt = 0; m_err = '0; m_cmd = '0; m_act = 0; m_end = 0;
    e_rvalid = 0; e_start = 0; e_done = 0; e_rdata = '0;
  endtask

  function automatic bit m_busy();
    return m_act && (cyc < m_end);
  endfunction

  function automatic logic [31:0] m_read(input int a, input bit b);
    if (a >= 4 && a < 4 + DC) return m_data[a-4];
    if (a == 'h10) return {m_halt, 30'b0, m_dmact};
    if (a == 'h16) return {19'b0, b, 1'b0, m_err, 4'b0, 4'(DC)};
    return '0;
  endfunction

  // Advance the model over cycle `cyc` with the given access.
  task automatic model_cycle(input bit r, input bit w, input int a, input logic [31:0] d);
    bit b, compl;
    b = m_busy();
    compl = b && (cyc == m_end - 1);
    e_rvalid = r; e_rdata = '0; e_start = 0; e_done = 0;
    if (r && !w) e_rdata = m_read(a, b);
    if (r && w) begin
      if (a >= 4 && a < 4 + DC) begin
        if (b) begin
          if (m_err == 0) m_err = 3'd1;
        end else m_data[a-4] = d;
      end else if (a == 'h10) begin
        m_dmact = d[0]; m_halt = d[31];
        if (!d[0]) begin
          for (int i = 0; i < DC; i++) m_data[i] = '0;
          m_err = '0; m_act = 0; m_cmd = '0; compl = 0;
        end
      end else if (a == 'h16) begin
        m_err = m_err & ~d[10:8];
      end else if (a == 'h17) begin
        if (m_err != 0) ;
        else if (b) m_err = 3'd1;
        else if (d[31:24] != 0) m_err = 3'd2;
        else begin
          m_cmd = d; e_start = 1; m_act = 1; m_end = cyc + 1 + BC;
        end
      end
    end
    if (compl) begin
      e_done = 1; m_data[0] = m_data[0] + 32'd1; m_act = 0;
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [6:0] a, input logic [31:0] d);
    req = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_cycle(r, w, int'(a), d);
    cyc++;
    #1;
    chk("rvalid", 32'(rvalid), 32'(e_rvalid));
    chk("rdata", rdata, e_rdata);
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("cmd", cmd, m_cmd);
    chk("start", 32'(cmd_start), 32'(e_start));
    chk("done", 32'(cmd_done), 32'(e_done));
    req = 0; we = 0;
  endtask

  task automatic async_reset();
    #2 rst_n = 0; req = 0; we = 0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_rvalid", 32'(rvalid), 0);
    chk("ar_rdata", rdata, 0);
    chk("ar_cmd", cmd, 0);
    chk("ar_start", 32'(cmd_start), 0);
    chk("ar_done", 32'(cmd_done), 0);
    model_reset();
    @(posedge clk); cyc++;
    #2 rst_n = 1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_done", 32'(cmd_done), 0);
    #4 rst_n = 1;

    step(1, 0, 7'h16, 0);          chk("cs_after_rst", rdata, 32'h2);
    step(1, 1, 7'h10, 1);
    step(1, 1, 7'h05, 32'hDEADBEEF);
    step(1, 0, 7'h05, 0);          chk("data1", rdata, 32'hDEADBEEF);
    step(1, 0, 7'h06, 0);          chk("beyond_end", rdata, 0);
    step(1, 1, 7'h06, 32'h1234);
    step(1, 0, 7'h06, 0);          chk("beyond_end_wr", rdata, 0);

    step(1, 1, 7'h17, 32'h00221005); chk("start_n1", 32'(cmd_start), 1);
    repeat (4) step(0, 0, 0, 0);     chk("done_n5", 32'(cmd_done), 1);
    step(1, 0, 7'h04, 0);            chk("data0_inc", rdata, 32'h1);
    chk("cmd_word", cmd, 32'h00221005);

    step(1, 1, 7'h17, 32'h00000001);
    step(1, 1, 7'h17, 32'h00000002);
    step(1, 0, 7'h16, 0);            chk("cs_busy_err", rdata, 32'h00001102);
    step(1, 1, 7'h17, 32'h00000003);
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 7'h16, 32'h00000100);
    step(1, 0, 7'h16, 0);            chk("cs_cleared", rdata, 32'h2);

    step(1, 1, 7'h17, 32'h01000000);
    step(1, 0, 7'h16, 0);            chk("cs_notsup", rdata, 32'h00000202);
    step(1, 1, 7'h16, 32'h00000700);
    step(1, 1, 7'h17, 32'h0);
    step(1, 1, 7'h04, 32'hAAAA5555);
    step(1, 0, 7'h16, 0);            chk("cs_datawr_busy", rdata, 32'h00001102);
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 7'h16, 32'h00000700);

    step(1, 1, 7'h04, 32'hFFFFFFFF); // completion wraps data0
    step(1, 1, 7'h17, 32'h0);
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 7'h04, 0);            chk("data0_wrap", rdata, 32'h0);

    step(1, 1, 7'h17, 32'h00000042);
    step(0, 0, 0, 0);
    step(1, 1, 7'h10, 0);            chk("abort_busy", 32'(busy), 0);
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 7'h05, 0);            chk("abort_data1", rdata, 0);
    step(1, 1, 7'h10, 1);
    step(1, 1, 7'h17, 32'h00000043);
    step(0, 0, 0, 0);
    async_reset();
    repeat (6) step(0, 0, 0, 0);
    step(1, 1, 7'h10, 1);

    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [6:0]  a;
      logic [31:0] d;
      bit r, w;
      r = ($urandom_range(0, 9) < 7);
      w = $urandom_range(0, 1);
      sel = $urandom_range(0, 10);
      case (sel)
        0: a = 7'h04; 1: a = 7'h05; 2: a = 7'h06; 3: a = 7'h10;
        4, 5: a = 7'h16; 6, 7, 8: a = 7'h17; 9: a = 7'h0F;
        default: a = 7'($urandom);
      endcase
      d = $urandom;
      if (a == 7'h10) d[0] = ($urandom_range(0, 15) != 0);
      if (a == 7'h17 && $urandom_range(0, 3) != 0) d[31:24] = 8'h0;
      step(r, w, a, d);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
